// File: rtl/commit_lockstep_scheduler_pkg.sv
// commit_lockstep_scheduler_pkg: scheduler state encoding, commit limit and effective-commit helper
package commit_lockstep_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FAULT = 2'd3} sched_state_e;
  localparam logic [1:0] MAX_COMNUM = 2'd2;
  function automatic logic [1:0] eff_commit(input logic [1:0] comnum, input logic prmiss);
    return prmiss ? 2'd0 : comnum;
  endfunction
endpackage

// File: rtl/commit_lockstep_scheduler_if.sv
// commit_lockstep_scheduler_if: OoO commit/address inputs, ISA ready inputs, step and credit outputs
//   master: drives commits, addresses and ready; observes step and credits
//   slave : the scheduler side
interface commit_lockstep_scheduler_if #(parameter int CREDIT_W = 4, parameter int ADDR_W = 32);
  logic [1:0]          ooo1_comnum_i, ooo2_comnum_i;
  logic                ooo1_prmiss_i, ooo2_prmiss_i;
  logic [ADDR_W-1:0]   ooo1_addr_i, ooo2_addr_i;
  logic                isa1_ready_i, isa2_ready_i;
  logic                isa_step_o;
  logic [CREDIT_W-1:0] credit1_o, credit2_o;
  modport master(output ooo1_comnum_i, ooo2_comnum_i, ooo1_prmiss_i, ooo2_prmiss_i, ooo1_addr_i,
                 ooo2_addr_i, isa1_ready_i, isa2_ready_i, input isa_step_o, credit1_o, credit2_o);
  modport slave(input ooo1_comnum_i, ooo2_comnum_i, ooo1_prmiss_i, ooo2_prmiss_i, ooo1_addr_i,
                ooo2_addr_i, isa1_ready_i, isa2_ready_i, output isa_step_o, credit1_o, credit2_o);
endinterface

// File: rtl/commit_lockstep_scheduler_credit_counter.sv
// commit_lockstep_scheduler_credit_counter: saturating step-credit counter for one OoO copy
//   eff/step add and remove credit while enable; freeze holds; otherwise cleared to 0
//   credit, nonzero, sat (next value exceeded the maximum)
module commit_lockstep_scheduler_credit_counter #(parameter int CREDIT_W = 4) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic [1:0]          eff,
  input  logic                step,
  input  logic                enable,
  input  logic                freeze,
  output logic [CREDIT_W-1:0] credit,
  output logic                nonzero,
  output logic                sat
);
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W+1:0] sum;
  always_comb begin
    sum      = {2'b00, credit_q} + (CREDIT_W+2)'(eff) - (CREDIT_W+2)'(step);
    sat      = enable & (|sum[CREDIT_W+1:CREDIT_W]);
    credit_d = freeze ? credit_q : !enable ? '0 : sat ? '1 : sum[CREDIT_W-1:0];
  end
  always_ff @(posedge clk or negedge reset_x)
    if (!reset_x) credit_q <= '0;
    else credit_q <= credit_d;
  assign credit  = credit_q;
  assign nonzero = |credit_q;
endmodule

// File: rtl/commit_lockstep_scheduler.sv
// commit_lockstep_scheduler: steps both ISA copies in lockstep with OoO commits and flags divergence
//   clk, reset_x (async active-low), start_i pulse, stop_i level, bus (commits/ready/step/credits)
//   state_o, sticky deviation_o/overflow_o, drained_o pulse on leaving DRAIN for IDLE
module commit_lockstep_scheduler
  import commit_lockstep_scheduler_pkg::*;
#(
  parameter int CREDIT_W    = 4,
  parameter int ADDR_W      = 32,
  parameter int DRAIN_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset_x,
  input  logic       start_i,
  input  logic       stop_i,
  commit_lockstep_scheduler_if.slave bus,
  output logic [1:0] state_o,
  output logic       deviation_o,
  output logic       overflow_o,
  output logic       drained_o
);
  localparam int TW = $clog2(DRAIN_LIMIT + 1);
  sched_state_e state_q, state_d;
  logic deviation_q, deviation_d, overflow_q, overflow_d, drained_q, drained_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0] eff1, eff2;
  logic [CREDIT_W-1:0] credit1, credit2;
  logic active, step, nz1, nz2, sat1, sat2, illegal, diverge, err, timeout, done;
  always_comb begin
    eff1    = eff_commit(bus.ooo1_comnum_i, bus.ooo1_prmiss_i);
    eff2    = eff_commit(bus.ooo2_comnum_i, bus.ooo2_prmiss_i);
    active  = state_q == RUN || state_q == DRAIN;
    step    = active & nz1 & nz2 & bus.isa1_ready_i & bus.isa2_ready_i;
    illegal = (eff1 > MAX_COMNUM) | (eff2 > MAX_COMNUM);
    // address compare is meaningless while either copy is squashing its commits
    diverge = (eff1 != eff2) |
              ((bus.ooo1_addr_i != bus.ooo2_addr_i) & !bus.ooo1_prmiss_i & !bus.ooo2_prmiss_i);
    err     = active & (diverge | illegal | sat1 | sat2);
    done    = !nz1 & !nz2;
    timer_d = state_q == DRAIN ? (step ? '0 : timer_q + 1'b1) : '0;
    timeout = state_q == DRAIN & timer_d == TW'(DRAIN_LIMIT) & !done;
    deviation_d = deviation_q | (active & diverge);
    overflow_d  = overflow_q | (active & (illegal | sat1 | sat2));
    drained_d   = state_q == DRAIN & !err & !timeout & done;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? RUN : IDLE;
      RUN:     state_d = err ? FAULT : stop_i ? DRAIN : RUN;
      DRAIN:   state_d = (err | timeout) ? FAULT : done ? IDLE : DRAIN;
      default: state_d = FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_x)
    if (!reset_x) begin
      state_q     <= IDLE;
      deviation_q <= 1'b0;
      overflow_q  <= 1'b0;
      drained_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      deviation_q <= deviation_d;
      overflow_q  <= overflow_d;
      drained_q   <= drained_d;
      timer_q     <= timer_d;
    end
  commit_lockstep_scheduler_credit_counter #(.CREDIT_W(CREDIT_W)) u_cnt1 (
    .clk(clk), .reset_x(reset_x), .eff(eff1), .step(step), .enable(active),
    .freeze(state_q == FAULT), .credit(credit1), .nonzero(nz1), .sat(sat1));
  commit_lockstep_scheduler_credit_counter #(.CREDIT_W(CREDIT_W)) u_cnt2 (
    .clk(clk), .reset_x(reset_x), .eff(eff2), .step(step), .enable(active),
    .freeze(state_q == FAULT), .credit(credit2), .nonzero(nz2), .sat(sat2));
  assign bus.isa_step_o = step;
  assign bus.credit1_o  = credit1;
  assign bus.credit2_o  = credit2;
  assign state_o        = state_q;
  assign deviation_o    = deviation_q;
  assign overflow_o     = overflow_q;
  assign drained_o      = drained_q;
endmodule

// File: tb/tb_commit_lockstep_scheduler.sv
// tb_commit_lockstep_scheduler: directed vectors with hand-computed expectations
module tb_commit_lockstep_scheduler;
  logic clk = 1'b0, reset_x = 1'b0, start_i = 1'b0, stop_i = 1'b0;
  logic [1:0] state_o;
  logic deviation_o, overflow_o, drained_o;
  int n_run = 0, n_fail = 0;
  commit_lockstep_scheduler_if bus();
  commit_lockstep_scheduler dut (
    .clk(clk), .reset_x(reset_x), .start_i(start_i), .stop_i(stop_i), .bus(bus),
    .state_o(state_o), .deviation_o(deviation_o), .overflow_o(overflow_o), .drained_o(drained_o));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input logic [1:0] c1, input logic p1, input logic [1:0] c2, input logic p2,
                       input logic [31:0] a1, input logic [31:0] a2, input logic r1, input logic r2);
    bus.ooo1_comnum_i = c1; bus.ooo1_prmiss_i = p1; bus.ooo2_comnum_i = c2; bus.ooo2_prmiss_i = p2;
    bus.ooo1_addr_i = a1; bus.ooo2_addr_i = a2; bus.isa1_ready_i = r1; bus.isa2_ready_i = r2;
  endtask
  task automatic restart();
    @(negedge clk);
    reset_x = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_x = 1'b1;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_state", state_o, 0);
    check("rst_step", bus.isa_step_o, 0);
    check("rst_credit", bus.credit1_o, 0);
    // lockstep
    restart();
    check("ls_run", state_o, 1);
    drive(2, 0, 2, 0, 0, 0, 1, 1);
    cyc(); check("ls_c1a", bus.credit1_o, 2); check("ls_c2a", bus.credit2_o, 2);
    cyc(); check("ls_c1b", bus.credit1_o, 3);
    cyc(); check("ls_c1c", bus.credit1_o, 4); check("ls_c2c", bus.credit2_o, 4);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    #1 check("ls_step", bus.isa_step_o, 1);
    for (int i = 3; i >= 0; i--) begin
      cyc(); check("ls_drain_credit", bus.credit1_o, i);
    end
    check("ls_step_end", bus.isa_step_o, 0);
    check("ls_dev", deviation_o, 0);
    check("ls_state", state_o, 1);
    // async reset mid-RUN
    drive(2, 0, 2, 0, 0, 0, 0, 0);
    cyc(); cyc();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(); check("ar_credit5", bus.credit1_o, 5);
    reset_x = 1'b0;
    #1;
    check("ar_credit", bus.credit1_o, 0); check("ar_state", state_o, 0);
    check("ar_step", bus.isa_step_o, 0); check("ar_flags", {deviation_o, overflow_o, drained_o}, 0);
    reset_x = 1'b1;
    // mispredict
    restart();
    drive(2, 1, 2, 1, 32'h100, 32'h104, 0, 0);
    cyc(); check("mp_credit", bus.credit1_o, 0); check("mp_dev", deviation_o, 0); check("mp_state", state_o, 1);
    drive(2, 1, 2, 0, 0, 0, 0, 0);
    cyc(); check("mp1_dev", deviation_o, 1); check("mp1_state", state_o, 3);
    // address divergence
    restart();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 1, 0, 32'h100, 32'h104, 1, 1);
    cyc(); check("ad_dev", deviation_o, 1); check("ad_state", state_o, 3);
    drive(2, 0, 2, 0, 0, 0, 1, 1);
    #1 check("ad_step", bus.isa_step_o, 0);
    cyc(); check("ad_frozen", bus.credit1_o, 1); check("ad_step2", bus.isa_step_o, 0);
    // saturation
    restart();
    drive(2, 0, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc();
    check("sat_c14", bus.credit1_o, 14); check("sat_ovf0", overflow_o, 0);
    cyc(); check("sat_c15", bus.credit1_o, 15); check("sat_ovf", overflow_o, 1); check("sat_state", state_o, 3);
    // illegal comnum
    restart();
    drive(3, 0, 3, 0, 0, 0, 0, 0);
    cyc(); check("ill_ovf", overflow_o, 1); check("ill_state", state_o, 3); check("ill_dev", deviation_o, 0);
    // drain
    restart();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(); cyc(); cyc();
    check("dr_c3", bus.credit2_o, 3);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    stop_i = 1'b1;
    cyc(); stop_i = 1'b0;
    check("dr_state", state_o, 2); check("dr_c2", bus.credit1_o, 2);
    cyc(); cyc(); check("dr_c0", bus.credit1_o, 0); check("dr_nopulse", drained_o, 0);
    cyc(); check("dr_pulse", drained_o, 1); check("dr_idle", state_o, 0);
    cyc(); check("dr_pulse_end", drained_o, 0);
    // drain timeout
    restart();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    stop_i = 1'b1;
    cyc(); stop_i = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    check("to_still_drain", state_o, 2);
    cyc(); check("to_fault", state_o, 3); check("to_ovf", overflow_o, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
